xgmii_udp_tx_engine: RTL and testbench

//  Transmit-side peer of the XGMII UDP receive path. On request, builds one fixed-format 64-byte

---
 rtl/xgmii_udp_tx_pkg.sv | 79 +++++++
 rtl/xgmii_udp_tx_engine_crc.sv | 28 ++
 rtl/xgmii_udp_tx_engine.sv | 169 ++++++++++++++++
 tb/tb_xgmii_udp_tx_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_udp_tx_pkg.sv
// Shared constants, state encoding and header helpers
// for the XGMII UDP transmit path.
package xgmii_udp_tx_pkg;

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_PRE   = 8'h55;
  localparam logic [7:0] XG_SFD   = 8'hD5;

  localparam logic [63:0] IDLE_WORD = {8{XG_IDLE}};
  localparam logic [63:0] PRE_WORD  =
    {XG_SFD, {6{XG_PRE}}, XG_START};
  localparam logic [63:0] TERM_WORD = {{7{XG_IDLE}}, XG_TERM};

  localparam logic [15:0] ETH_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [15:0] IP_TOTAL_LEN = 16'h002A;
  localparam logic [15:0] IP_FLAGS     = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] UDP_LEN      = 16'h0016;
  localparam logic [31:0] MAGIC_CODE   = 32'hA5C3_0F1E;
  localparam logic [31:0] CRC_POLY_R   = 32'hEDB8_8320;

  localparam int OFS_DMAC    = 0;
  localparam int OFS_SMAC    = 6;
  localparam int OFS_TYPE    = 12;
  localparam int OFS_IP      = 14;
  localparam int OFS_ID      = 18;
  localparam int OFS_TTL     = 22;
  localparam int OFS_CSUM    = 24;
  localparam int OFS_SIP     = 26;
  localparam int OFS_SPORT   = 34;
  localparam int OFS_MAGIC   = 42;
  localparam int OFS_PAYLOAD = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_PRE,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } tx_state_t;

  // Byte swaps place big-endian fields into little-endian lanes
  function automatic logic [15:0] be16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] be32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [47:0] be48(input logic [47:0] v);
    return {v[7:0], v[15:8], v[23:16],
            v[31:24], v[39:32], v[47:40]};
  endfunction

  function automatic logic [15:0] ip_checksum(
    input logic [15:0] id,
    input logic [7:0]  ttl,
    input logic [31:0] sip,
    input logic [31:0] dip
  );
    logic [19:0] s;
    s = {4'h0, IP_VER_IHL, 8'h00}
      + {4'h0, IP_TOTAL_LEN}
      + {4'h0, id}
      + {4'h0, IP_FLAGS}
      + {4'h0, ttl, IP_PROTO_UDP}
      + {4'h0, sip[31:16]} + {4'h0, sip[15:0]}
      + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_udp_tx_engine_crc.sv
// Combinational reflected CRC-32 step over the low
// nbytes lanes of a 64-bit word (lane 0 first).
module crc32_d64
  import xgmii_udp_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        c = c ^ {24'h0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ({1'b0, c[31:1]} ^ CRC_POLY_R)
                   : {1'b0, c[31:1]};
        end
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/xgmii_udp_tx_engine.sv
// Builds one fixed 64-byte Ethernet/IPv4/UDP frame per
// request and drives it with FCS onto XGMII TX.
module xgmii_udp_tx_engine
  import xgmii_udp_tx_pkg::*;
#(
  parameter logic [15:0] UDP_PORT  = 16'd3422,
  parameter logic [31:0] MAGIC     = MAGIC_CODE,
  parameter logic [7:0]  IP_TTL    = 8'd64,
  parameter int          IFG_WORDS = 1
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] if_macaddr,
  input  logic [31:0] dest_v4addr,
  input  logic [47:0] dest_macaddr,
  input  logic        tx_req,
  input  logic [63:0] tx_data,
  output logic        tx_ack,
  output logic        tx_busy,
  output logic [31:0] tx_frames,
  output logic [7:0]  xgmii_txc,
  output logic [63:0] xgmii_txd
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_WORDS - 1);

  tx_state_t   state, next;
  logic [2:0]  word_cnt;
  logic [7:0]  ifg_cnt;
  logic [31:0] sip, dip;
  logic [47:0] smac, dmac;
  logic [63:0] payload;
  logic [15:0] ip_id, csum;
  logic [31:0] crc_reg, crc_next;
  logic [511:0] fr;
  logic [63:0] cur_word;
  logic [7:0]  txc_d;
  logic [63:0] txd_d;
  logic        accept, last_word, ifg_done;

  assign accept    = (state == ST_IDLE) && tx_req;
  assign last_word = (state == ST_DATA) && (word_cnt == 3'd7);
  assign ifg_done  = (state == ST_IFG) && (ifg_cnt == IFG_LAST);

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: if (tx_req) next = ST_CSUM;
      ST_CSUM: next = ST_PRE;
      ST_PRE:  next = ST_DATA;
      ST_DATA: if (word_cnt == 3'd7) next = ST_TERM;
      ST_TERM: next = ST_IFG;
      ST_IFG:  if (ifg_cnt == IFG_LAST) next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    txc_d = 8'hff;
    txd_d = IDLE_WORD;
    unique case (state)
      ST_PRE: begin
        txc_d = 8'h01;
        txd_d = PRE_WORD;
      end
      ST_DATA: begin
        txc_d = 8'h00;
        txd_d = last_word ? {~crc_next, 32'h0}
                          : cur_word;
      end
      ST_TERM: txd_d = TERM_WORD;
      default: ;
    endcase
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_cnt <= '0;
      ifg_cnt  <= '0;
    end else begin
      word_cnt <= (state == ST_DATA) ? word_cnt + 3'd1 : '0;
      ifg_cnt  <= (state == ST_IFG) ? ifg_cnt + 8'd1 : '0;
    end
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sip     <= '0;
      dip     <= '0;
      smac    <= '0;
      dmac    <= '0;
      payload <= '0;
    end else if (accept) begin
      sip     <= if_v4addr;
      dip     <= dest_v4addr;
      smac    <= if_macaddr;
      dmac    <= dest_macaddr;
      payload <= tx_data;
    end
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csum    <= '0;
      ip_id   <= '0;
      crc_reg <= '1;
    end else begin
      if (state == ST_CSUM)
        csum <= ip_checksum(ip_id, IP_TTL, sip, dip);
      if (ifg_done)
        ip_id <= ip_id + 16'd1;
      if (state == ST_PRE)
        crc_reg <= '1;
      else if (state == ST_DATA)
        crc_reg <= crc_next;
    end
  end

  // Whole frame image, byte n at bits [8n+7:8n]
  always_comb begin
    fr = '0;
    fr[8*OFS_DMAC +: 48]    = be48(dmac);
    fr[8*OFS_SMAC +: 48]    = be48(smac);
    fr[8*OFS_TYPE +: 16]    = be16(ETH_IPV4);
    fr[8*OFS_IP +: 32]      =
      be32({IP_VER_IHL, 8'h00, IP_TOTAL_LEN});
    fr[8*OFS_ID +: 32]      = be32({ip_id, IP_FLAGS});
    fr[8*OFS_TTL +: 16]     = be16({IP_TTL, IP_PROTO_UDP});
    fr[8*OFS_CSUM +: 16]    = be16(csum);
    fr[8*OFS_SIP +: 64]     = {be32(dip), be32(sip)};
    fr[8*OFS_SPORT +: 64]   =
      {16'h0, be16(UDP_LEN), be16(UDP_PORT), be16(UDP_PORT)};
    fr[8*OFS_MAGIC +: 32]   = be32(MAGIC);
    fr[8*OFS_PAYLOAD +: 64] = payload;
  end

  assign cur_word = fr[64*word_cnt +: 64];

  // Last word only folds the 4 pad bytes before FCS
  crc32_d64 u_crc (
    .crc_in  (crc_reg),
    .data    (cur_word),
    .nbytes  ((word_cnt == 3'd7) ? 4'd4 : 4'd8),
    .crc_out (crc_next)
  );

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xgmii_txc <= 8'hff;
      xgmii_txd <= IDLE_WORD;
      tx_ack    <= 1'b0;
      tx_busy   <= 1'b0;
      tx_frames <= '0;
    end else begin
      xgmii_txc <= txc_d;
      xgmii_txd <= txd_d;
      tx_ack    <= accept;
      tx_busy   <= (next != ST_IDLE);
      if (ifg_done) tx_frames <= tx_frames + 32'd1;
    end
  end

endmodule

// File: tb/tb_xgmii_udp_tx_engine.sv
// Directed bench for the XGMII UDP TX engine with a
// byte-level frame model and CRC/checksum decoders.
module tb_xgmii_udp_tx_engine;

  localparam logic [31:0] TB_MAGIC = 32'hA5C3_0F1E;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_v4addr, dest_v4addr;
  logic [47:0] if_macaddr, dest_macaddr;
  logic        tx_req;
  logic [63:0] tx_data;
  logic        tx_ack, tx_busy;
  logic [31:0] tx_frames;
  logic [7:0]  txc;
  logic [63:0] txd;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] rx [64];
  logic [7:0] ex [64];

  xgmii_udp_tx_engine #(.MAGIC(TB_MAGIC)) dut (
    .xgmii_clk    (clk),
    .sys_rst_n    (rst_n),
    .if_v4addr    (if_v4addr),
    .if_macaddr   (if_macaddr),
    .dest_v4addr  (dest_v4addr),
    .dest_macaddr (dest_macaddr),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ack       (tx_ack),
    .tx_busy      (tx_busy),
    .tx_frames    (tx_frames),
    .xgmii_txc    (txc),
    .xgmii_txd    (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_exp(input logic [15:0] id,
                           input logic [47:0] dm,
                           input logic [47:0] sm,
                           input logic [31:0] si,
                           input logic [31:0] di,
                           input logic [63:0] pd);
    logic [19:0] s;
    logic [31:0] c;
    for (int n = 0; n < 64; n++) ex[n] = 8'h00;
    for (int j = 0; j < 6; j++) begin
      ex[j]     = dm[47-8*j -: 8];
      ex[6 + j] = sm[47-8*j -: 8];
    end
    ex[12] = 8'h08; ex[13] = 8'h00; ex[14] = 8'h45;
    ex[16] = 8'h00; ex[17] = 8'h2A;
    ex[18] = id[15:8]; ex[19] = id[7:0];
    ex[20] = 8'h40; ex[22] = 8'd64; ex[23] = 8'h11;
    for (int j = 0; j < 4; j++) begin
      ex[26 + j] = si[31-8*j -: 8];
      ex[30 + j] = di[31-8*j -: 8];
    end
    ex[34] = 8'h0D; ex[35] = 8'h5E;
    ex[36] = 8'h0D; ex[37] = 8'h5E;
    ex[39] = 8'h16;
    for (int j = 0; j < 4; j++) ex[42 + j] = TB_MAGIC[31-8*j -: 8];
    for (int j = 0; j < 8; j++) ex[48 + j] = pd[8*j +: 8];
    s = '0;
    for (int n = 14; n < 34; n += 2) s += {4'h0, ex[n], ex[n+1]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    ex[24] = ~s[15:8]; ex[25] = ~s[7:0];
    c = 32'hFFFFFFFF;
    for (int n = 0; n < 60; n++) c = crc_upd(c, ex[n]);
    c = ~c;
    for (int j = 0; j < 4; j++) ex[60 + j] = c[8*j +: 8];
  endtask

  task automatic capture(output int gap);
    bit found;
    gap = 0;
    found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (txc == 8'h01 && txd == PRE_W) found = 1;
      else if (txc == 8'hff && txd == IDLE_W) gap += 8;
    end
    check("preamble_seen", 64'(found), 64'd1);
    if (!found) return;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      check("data_txc", 64'(txc), 64'h00);
      for (int j = 0; j < 8; j++) rx[8*w + j] = txd[8*j +: 8];
    end
    @(negedge clk);
    check("term_txc", 64'(txc), 64'hff);
    check("term_txd", txd, TERM_W);
  endtask

  task automatic verify(input logic [15:0] id,
                        input logic [47:0] dm,
                        input logic [47:0] sm,
                        input logic [31:0] si,
                        input logic [31:0] di,
                        input logic [63:0] pd);
    logic [63:0] g, e;
    logic [19:0] s;
    logic [31:0] c;
    build_exp(id, dm, sm, si, di, pd);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        g[8*j +: 8] = rx[8*w + j];
        e[8*j +: 8] = ex[8*w + j];
      end
      check($sformatf("word%0d", w + 1), g, e);
    end
    check("ip_id", 64'({rx[18], rx[19]}), 64'(id));
    s = '0;
    for (int n = 14; n < 34; n += 2) s += {4'h0, rx[n], rx[n+1]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    check("ip_hdr_sum", 64'(s[15:0]), 64'hFFFF);
    c = 32'hFFFFFFFF;
    for (int n = 0; n < 64; n++) c = crc_upd(c, rx[n]);
    check("fcs_residue", 64'(c), 64'hDEBB20E3);
  endtask

  task automatic send_req();
    tx_req = 1'b1;
    @(negedge clk);
    check("ack", 64'(tx_ack), 64'd1);
    check("busy_on_ack", 64'(tx_busy), 64'd1);
    tx_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && tx_busy; n++) @(negedge clk);
    check("busy_drop", 64'(tx_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, acks, pres;
    logic [31:0] old_dip;
    logic [63:0] old_data;

    rst_n = 1'b0;
    tx_req = 1'b0;
    if_v4addr = 32'h0A000001;
    if_macaddr = 48'h001122334455;
    dest_v4addr = 32'h0A000002;
    dest_macaddr = 48'h66778899AABB;
    tx_data = 64'h0807060504030201;
    repeat (3) @(negedge clk);
    check("rst_txc", 64'(txc), 64'hff);
    check("rst_txd", txd, IDLE_W);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_ack", 64'(tx_ack), 64'd0);
    check("rst_frames", 64'(tx_frames), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_req();
    repeat (3) @(negedge clk);
    check("mid_in_data", 64'(txc), 64'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txc", 64'(txc), 64'hff);
    check("mid_rst_txd", txd, IDLE_W);
    @(negedge clk);
    check("mid_rst_busy", 64'(tx_busy), 64'd0);
    check("mid_rst_idle", txd, IDLE_W);
    check("mid_rst_frames", 64'(tx_frames), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tx_req = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture(gap);
      verify(16'(f), dest_macaddr, if_macaddr,
             if_v4addr, dest_v4addr, tx_data);
      if (f > 0)
        check("ifg_bytes", 64'((gap + 7) >= 15), 64'd1);
    end
    tx_req = 1'b0;
    wait_idle();
    check("b2b_frames", 64'(tx_frames), 64'd3);

    send_req();
    capture(gap);
    verify(16'd3, dest_macaddr, if_macaddr,
           if_v4addr, dest_v4addr, tx_data);
    check("byte48", 64'(rx[48]), 64'h01);
    check("magic", 64'({rx[42], rx[43], rx[44], rx[45]}),
          64'(TB_MAGIC));
    check("ip_csum", 64'({rx[24], rx[25]}), 64'h26BE);
    check("dst_mac0", 64'(rx[0]), 64'h66);
    check("ethertype", 64'({rx[12], rx[13]}), 64'h0800);
    wait_idle();
    check("single_frames", 64'(tx_frames), 64'd4);

    send_req();
    repeat (4) @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    acks = 0;
    pres = 0;
    for (int n = 0; n < 40; n++) begin
      if (tx_ack) acks++;
      @(negedge clk);
      if (txc == 8'h01 && txd == PRE_W) pres++;
    end
    check("busy_no_ack", 64'(acks), 64'd0);
    check("busy_no_frame", 64'(pres), 64'd0);
    check("busy_frames", 64'(tx_frames), 64'd5);

    old_dip = dest_v4addr;
    old_data = tx_data;
    send_req();
    dest_v4addr = 32'h0A000063;
    tx_data = 64'hFFEEDDCCBBAA9988;
    capture(gap);
    verify(16'd5, dest_macaddr, if_macaddr,
           if_v4addr, old_dip, old_data);
    dest_v4addr = old_dip;
    tx_data = old_data;
    wait_idle();

    @(negedge clk);
    force dut.ip_id = 16'hFFFF;
    @(negedge clk);
    release dut.ip_id;
    @(negedge clk);
    send_req();
    capture(gap);
    verify(16'hFFFF, dest_macaddr, if_macaddr,
           if_v4addr, dest_v4addr, tx_data);
    wait_idle();
    send_req();
    capture(gap);
    verify(16'h0000, dest_macaddr, if_macaddr,
           if_v4addr, dest_v4addr, tx_data);
    wait_idle();
    check("final_frames", 64'(tx_frames), 64'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
